usb_tx_phy: RTL and testbench

- Transmit half of the USB full/low-speed transceiver, driving the `phy` side of the transceiver interface toward the SIE.
- Accepts bytes from the SIE on the `tx_data`/`tx_valid`/`tx_ready` handshake.
- Emits SYNC, NRZI-encoded and bit-stuffed data (LSB first), then EOP on the D+/D- pads with output enable.
- Sits between the SIE and the bidirectional pad buffers; the receive path is a separate block.

---
 rtl/usb_tx_phy_if.sv | 13 +
 rtl/usb_tx_phy.sv | 192 +++++++++++++++++++
 tb/tb_usb_tx_phy.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/usb_tx_phy_if.sv
// SIE-to-PHY transmit byte handshake.
//   tx_data  : byte to send, held stable while tx_valid=1 until tx_ready
//   tx_valid : packet request / more-data flag from the SIE
//   tx_ready : one-cycle pulse when the PHY captures tx_data
// master = SIE side, slave = PHY side.
interface usb_tx_phy_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/usb_tx_phy.sv
// USB full/low-speed transmit PHY: SYNC, NRZI + bit-stuffed data (LSB first),
// then SE0/SE0/J end-of-packet, with pad output enable.
//   i_clk    : USB clock, rising edge
//   i_reset  : synchronous active-high reset (aborts a packet, no EOP)
//   io_sie   : byte handshake from the SIE (slave side)
//   o_tx_dp  : D+ drive value
//   o_tx_dn  : D- drive value
//   o_tx_oe  : pad output enable, first SYNC bit through EOP J bit
module usb_tx_phy #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter bit          LOW_SPEED    = 1'b0
) (
  input  logic            i_clk,
  input  logic            i_reset,
  usb_tx_phy_if.slave     io_sie,
  output logic            o_tx_dp,
  output logic            o_tx_dn,
  output logic            o_tx_oe
);

  localparam int unsigned TW          = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic        J_DP        = !LOW_SPEED;
  localparam logic [2:0]  STUFF_LIMIT = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_EOP_SE0,
    S_EOP_J
  } state_t;

  state_t          r_state;
  logic [TW-1:0]   r_timer;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic [2:0]      r_stuff_cnt;
  logic            r_level;     // NRZI line level, 1 = J
  logic            r_ready;
  logic            r_dp;
  logic            r_dn;
  logic            r_oe;

  logic            w_bit_end;
  logic            w_stuff_due;
  logic            w_last_bit;
  logic            w_bit;
  logic            w_level_nxt;
  logic [2:0]      w_cnt_nxt;
  logic [1:0]      w_pads_nxt;

  assign w_bit_end   = (r_timer == TW'(CLKS_PER_BIT - 1));
  assign w_stuff_due = (r_stuff_cnt == STUFF_LIMIT);
  assign w_last_bit  = (r_bit_idx == 3'd7);

  // Raw bit that goes on the wire at the next bit time (only used where a bit is emitted).
  // SYNC is 0000_0001: only bit 7 is a one. From IDLE the first SYNC bit is a zero.
  always_comb begin
    w_bit = 1'b0;
    case (r_state)
      S_SYNC: w_bit = w_last_bit ? io_sie.tx_data[0] : (r_bit_idx == 3'd6);
      S_DATA: begin
        if (w_stuff_due)     w_bit = 1'b0;
        else if (w_last_bit) w_bit = io_sie.tx_data[0];
        else                 w_bit = r_shift[1];
      end
      default: w_bit = 1'b0;
    endcase
    // NRZI: zero toggles the line, one holds it; zeros clear the run of ones
    w_level_nxt = w_bit ? r_level : ~r_level;
    w_cnt_nxt   = w_bit ? (r_stuff_cnt + 3'd1) : 3'd0;
    w_pads_nxt  = w_level_nxt ? {J_DP, ~J_DP} : {~J_DP, J_DP};
  end

  // Transmit sequencer; all outputs registered
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'd0;
      r_stuff_cnt <= 3'd0;
      r_level     <= 1'b1;
      r_ready     <= 1'b0;
      r_dp        <= J_DP;
      r_dn        <= ~J_DP;
      r_oe        <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      if (r_state != S_IDLE) r_timer <= w_bit_end ? '0 : (r_timer + TW'(1));

      case (r_state)
        S_IDLE: begin
          if (io_sie.tx_valid) begin
            r_state          <= S_SYNC;
            r_timer          <= '0;
            r_bit_idx        <= 3'd0;
            r_oe             <= 1'b1;
            r_level          <= w_level_nxt;
            r_stuff_cnt      <= w_cnt_nxt;
            {r_dp, r_dn}     <= w_pads_nxt;
          end
        end

        S_SYNC: begin
          if (w_bit_end) begin
            if (!w_last_bit) begin
              r_bit_idx      <= r_bit_idx + 3'd1;
              r_level        <= w_level_nxt;
              r_stuff_cnt    <= w_cnt_nxt;
              {r_dp, r_dn}   <= w_pads_nxt;
            end else if (io_sie.tx_valid) begin
              r_state        <= S_DATA;
              r_shift        <= io_sie.tx_data;
              r_ready        <= 1'b1;
              r_bit_idx      <= 3'd0;
              r_level        <= w_level_nxt;
              r_stuff_cnt    <= w_cnt_nxt;
              {r_dp, r_dn}   <= w_pads_nxt;
            end else begin
              r_state        <= S_EOP_SE0;
              r_bit_idx      <= 3'd0;
              {r_dp, r_dn}   <= 2'b00;
            end
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            if (w_stuff_due) begin
              // stuffed zero: bit index and shift register hold
              r_level        <= w_level_nxt;
              r_stuff_cnt    <= w_cnt_nxt;
              {r_dp, r_dn}   <= w_pads_nxt;
            end else if (!w_last_bit) begin
              r_bit_idx      <= r_bit_idx + 3'd1;
              r_shift        <= r_shift >> 1;
              r_level        <= w_level_nxt;
              r_stuff_cnt    <= w_cnt_nxt;
              {r_dp, r_dn}   <= w_pads_nxt;
            end else if (io_sie.tx_valid) begin
              // byte boundary with more data; stuff count carries across
              r_shift        <= io_sie.tx_data;
              r_ready        <= 1'b1;
              r_bit_idx      <= 3'd0;
              r_level        <= w_level_nxt;
              r_stuff_cnt    <= w_cnt_nxt;
              {r_dp, r_dn}   <= w_pads_nxt;
            end else begin
              r_state        <= S_EOP_SE0;
              r_bit_idx      <= 3'd0;
              {r_dp, r_dn}   <= 2'b00;
            end
          end
        end

        S_EOP_SE0: begin
          if (w_bit_end) begin
            if (r_bit_idx == 3'd1) begin
              r_state        <= S_EOP_J;
              r_bit_idx      <= 3'd0;
              r_dp           <= J_DP;
              r_dn           <= ~J_DP;
            end else begin
              r_bit_idx      <= r_bit_idx + 3'd1;
            end
          end
        end

        S_EOP_J: begin
          if (w_bit_end) begin
            r_state          <= S_IDLE;
            r_timer          <= '0;
            r_oe             <= 1'b0;
            r_level          <= 1'b1;
            r_stuff_cnt      <= 3'd0;
            r_dp             <= J_DP;
            r_dn             <= ~J_DP;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_sie.tx_ready = r_ready;
  assign o_tx_dp         = r_dp;
  assign o_tx_dn         = r_dn;
  assign o_tx_oe         = r_oe;

endmodule

// File: tb/tb_usb_tx_phy.sv
// Bench for usb_tx_phy: a full-speed instance (4 clk/bit) and a low-speed
// instance (2 clk/bit). Expected line/oe/ready per cycle come from a
// bit-stream model: SYNC + bytes LSB first, a zero inserted after six ones,
// NRZI over the stuffed stream, then SE0 SE0 J.
module tb_usb_tx_phy;

  localparam int unsigned CPB0 = 4;
  localparam int unsigned CPB1 = 2;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, rst1;
  logic       dp0, dn0, oe0, dp1, dn1, oe1;

  usb_tx_phy_if if0 ();
  usb_tx_phy_if if1 ();

  logic       valid_drv [2];
  logic [7:0] data_drv  [2];

  assign if0.tx_valid = valid_drv[0];
  assign if0.tx_data  = data_drv[0];
  assign if1.tx_valid = valid_drv[1];
  assign if1.tx_data  = data_drv[1];

  usb_tx_phy #(.CLKS_PER_BIT(CPB0), .LOW_SPEED(1'b0)) u_fs (
    .i_clk(clk), .i_reset(rst0), .io_sie(if0),
    .o_tx_dp(dp0), .o_tx_dn(dn0), .o_tx_oe(oe0)
  );

  usb_tx_phy #(.CLKS_PER_BIT(CPB1), .LOW_SPEED(1'b1)) u_ls (
    .i_clk(clk), .i_reset(rst1), .io_sie(if1),
    .o_tx_dp(dp1), .o_tx_dn(dn1), .o_tx_oe(oe1)
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // {oe, dp, dn, ready}
  function automatic logic [3:0] sample(input int d);
    if (d == 0) return {oe0, dp0, dn0, if0.tx_ready};
    return {oe1, dp1, dn1, if1.tx_ready};
  endfunction

  function automatic logic [1:0] jcode(input int d);
    return (d == 0) ? 2'b10 : 2'b01;
  endfunction

  task automatic set_drv(input int d, input logic v, input logic [7:0] b);
    valid_drv[d] = v;
    data_drv[d]  = b;
  endtask

  task automatic set_rst(input int d, input logic v);
    if (d == 0) rst0 = v;
    else        rst1 = v;
  endtask

  // Reference model: per-cycle expectation for one packet starting at the first SYNC cycle
  function automatic void build_exp(input int d, input bq_t pkt);
    int unsigned cpb = (d == 0) ? CPB0 : CPB1;
    logic [1:0]  j   = jcode(d);
    logic        bits[$];
    logic        first[$];
    logic [1:0]  sym[$];
    logic        rdy[$];
    logic        lvl_j = 1'b1;
    int          ones  = 0;
    for (int i = 0; i < 8; i++) begin
      bits.push_back(i == 7);
      first.push_back(1'b0);
    end
    foreach (pkt[n]) begin
      logic [7:0] b = pkt[n];
      for (int i = 0; i < 8; i++) begin
        bits.push_back(b[i]);
        first.push_back(i == 0);
      end
    end
    foreach (bits[i]) begin
      if (!bits[i]) lvl_j = ~lvl_j;
      sym.push_back(lvl_j ? j : ~j);
      rdy.push_back(first[i]);
      ones = bits[i] ? ones + 1 : 0;
      if (ones == 6) begin
        lvl_j = ~lvl_j;
        sym.push_back(lvl_j ? j : ~j);
        rdy.push_back(1'b0);
        ones = 0;
      end
    end
    sym.push_back(2'b00); rdy.push_back(1'b0);
    sym.push_back(2'b00); rdy.push_back(1'b0);
    sym.push_back(j);     rdy.push_back(1'b0);
    exp_q.delete();
    foreach (sym[i])
      for (int c = 0; c < int'(cpb); c++)
        exp_q.push_back({1'b1, sym[i], rdy[i] && (c == 0)});
  endfunction

  task automatic idle_cycles(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("d%0d_idle", d), 32'(sample(d)), 32'({1'b0, jcode(d), 1'b0}));
    end
  endtask

  // Entered at a negedge with the DUT idle. abort_at >= 0 resets the DUT at that cycle.
  task automatic send_packet(input int d, input bq_t pkt, input int abort_at,
                             input bit b2b_next, input logic [7:0] next_first);
    int         idx    = 0;
    bit         glitch = 1'b0;
    logic [3:0] got;
    build_exp(d, pkt);
    set_drv(d, 1'b1, pkt[0]);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      got = sample(d);
      check($sformatf("d%0d_cyc%0d", d, k), 32'(got), 32'(exp_q[k]));
      if (k == abort_at) begin
        set_rst(d, 1'b1);
        set_drv(d, 1'b0, 8'($urandom));
        @(negedge clk);
        check($sformatf("d%0d_abort", d), 32'(sample(d)), 32'({1'b0, jcode(d), 1'b0}));
        set_rst(d, 1'b0);
        return;
      end
      if (glitch) begin
        valid_drv[d] = 1'b1;
        glitch = 1'b0;
      end
      if (got[0]) begin
        idx++;
        if (idx < pkt.size()) begin
          // a brief mid-byte drop of tx_valid must not end the packet
          glitch = ($urandom_range(0, 1) == 1);
          set_drv(d, !glitch, pkt[idx]);
        end else begin
          set_drv(d, 1'b0, 8'($urandom));
        end
      end
      if (b2b_next && idx >= pkt.size() && got[3] && got[2:1] == 2'b00)
        set_drv(d, 1'b1, next_first);
    end
    @(negedge clk);
    check($sformatf("d%0d_eop_idle", d), 32'(sample(d)), 32'({1'b0, jcode(d), 1'b0}));
    if (!b2b_next) set_drv(d, 1'b0, 8'($urandom));
  endtask

  task automatic make_pkt(output bq_t p);
    int n = $urandom_range(1, 4);
    p.delete();
    for (int i = 0; i < n; i++)
      p.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
  endtask

  initial begin
    bq_t p, q;
    rst0 = 1'b1; rst1 = 1'b1;
    set_drv(0, 1'b0, 8'h00);
    set_drv(1, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    check("fs_reset", 32'(sample(0)), 32'({1'b0, 2'b10, 1'b0}));
    check("ls_reset", 32'(sample(1)), 32'({1'b0, 2'b01, 1'b0}));
    rst0 = 1'b0; rst1 = 1'b0;
    idle_cycles(0, 2);

    // ACK, end-of-byte stuffing, stuffing across a byte boundary
    p = '{8'hD2};        send_packet(0, p, -1, 1'b0, 8'h00); idle_cycles(0, 2);
    p = '{8'hFC};        send_packet(0, p, -1, 1'b0, 8'h00); idle_cycles(0, 1);
    p = '{8'hC0, 8'h0F}; send_packet(0, p, -1, 1'b0, 8'h00);

    // reset during bit 3 of the first data byte, then a clean packet
    p = '{8'hA5, 8'h3C}; send_packet(0, p, (8 + 3) * CPB0 + 1, 1'b0, 8'h00);
    idle_cycles(0, 1);
    p = '{8'hD2};        send_packet(0, p, -1, 1'b0, 8'h00);

    // low-speed back-to-back with tx_valid held through EOP
    p = '{8'hC3};        send_packet(1, p, -1, 1'b1, 8'h5A);
    p = '{8'h5A, 8'hFF}; send_packet(1, p, -1, 1'b0, 8'h00);
    idle_cycles(1, 1);

    for (int i = 0; i < 15; i++) begin
      make_pkt(p);
      send_packet(0, p, -1, 1'b0, 8'h00);
      idle_cycles(0, $urandom_range(0, 3));
    end

    make_pkt(p);
    for (int i = 0; i < 10; i++) begin
      bit b2b = ($urandom_range(0, 1) == 1);
      make_pkt(q);
      send_packet(1, p, -1, b2b, q[0]);
      if (!b2b) idle_cycles(1, $urandom_range(0, 2));
      p = q;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
